arbitration_field_tx: RTL and testbench
=======================================

# arbitration_field_tx

Parametrised transmitter for the complete CAN arbitration field, supporting both standard (11-bit) and extended (29-bit) identifier frames. Triggered by SOF completion, it serialises the identifier bits followed by SRR/IDE where applicable and RTR, one bit per non-stuff sample point. It sits between the SOF generator and the control-field serializer in the Data Frame transmit path. It reports arbitration-field completion, reserved-identifier rejection and (optionally) arbitration loss.

## Interface
- EXT_SUPPORT, 1, 1 = extended frames allowed; 0 = `ide` ignored, always standard format
- CNT_W, 6, width of `bit_counter`; must be ≥ 6
- One clock; reset is asynchronous and active-high.
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- enable  input  1  block enable; low = synchronous clear to reset values
- sample_point  input  1  one-cycle strobe at each bit-time sample point
- stuff_bit_inserted  input  1  current bit time is a stuff bit; do not advance
- sof_complete  input  1  start trigger, honoured only in IDLE
- ide  input  1  frame format: 0 = standard, 1 = extended (sampled in IDLE)
- rtr  input  1  remote-transmission-request value (sampled in IDLE)
- identifier  input  29  standard: ID in [10:0]; extended: base ID in [28:18], extension in [17:0]
- rx_bit  input  1  bus value sampled at sample_point (used only with ARB_LOSS_DETECT_EN)
- bit_arb  output  1  bit currently driven to the bus; 1 = recessive
- bit_counter  output  CNT_W  number of arbitration bits consumed
- arb_complete  output  1  high for one cycle after the last bit is consumed
- arb_lost  output  1  one-cycle pulse on arbitration loss
- id_error  output  1  one-cycle pulse when a reserved identifier is rejected
- busy  output  1  high in every state except IDLE

## Operation
- Reset and `enable` = 0 values: state IDLE, `bit_arb` = 1, `bit_counter` = 0, all other outputs 0, shift register all-ones.
- Effective format: extended when `EXT_SUPPORT` = 1 and `ide` = 1; otherwise standard.
- Field sequence, MSB first:
  - Standard: ID[10:0], RTR. Length 12.
  - Extended: base[10:0], SRR = 1, IDE = 1, ext[17:0], RTR. Length 32.
- Reserved check: the base ID (standard ID or `identifier`[28:18]) with bits [10:4] = 7'h7F is invalid.
- States:
  - IDLE:
    - On `sof_complete` with a valid ID, go to LOAD and latch the format and `rtr`.
    - On `sof_complete` with an invalid ID, pulse `id_error` and stay in IDLE.
  - LOAD: build a 32-bit left-aligned frame word; `bit_arb` ← frame[31]; shift register ← frame << 1 (fill with 1s); `bit_counter` ← 0; go to SHIFT.
  - SHIFT: on `sample_point` && !`stuff_bit_inserted`:
    - Normal bit: `bit_arb` ← shreg[31]; shift left; `bit_counter`++.
    - Last bit (`bit_counter` == length−1): `bit_arb` ← 1; go to DONE.
    - Any other cycle: hold everything.
  - DONE: `arb_complete` = 1 for exactly one cycle; `bit_counter` holds the length (12 or 32); go to IDLE.
  - LOST (only with the macro): `bit_arb` = 1; return to IDLE the next cycle.
- `sof_complete` outside IDLE is ignored.
- `identifier`, `ide` and `rtr` changes after LOAD have no effect.
- A stuff-bit strobe never advances the counter or the shift register.

## Timing
- Start latency: `sof_complete` at cycle N → LOAD at N+1 → SHIFT at N+2. The first `bit_arb` value is valid from N+2.
- `bit_arb` changes one cycle after each consumed sample point, so the bit sampled at a strobe is the value present at that strobe.
- `arb_complete` is registered: high in the cycle after the final consumed sample point.
- Asynchronous `reset` mid-frame forces reset values immediately.
- `enable` low mid-frame clears everything on the next edge; no `arb_complete` is produced.

## Configuration
- `ARB_LOSS_DETECT_EN` defined:
  - In SHIFT, at a consumed sample point with `bit_arb` = 1 and `rx_bit` = 0:
    - Pulse `arb_lost` in the next cycle.
    - Go to LOST.
    - `bit_counter` freezes at the losing bit index.
  - This also covers losing at SRR/IDE to a standard frame.
  - Dominant-sent/recessive-read is not handled here; it is a bit error owned by the bit monitor.
- Macro undefined: `rx_bit` is ignored, `arb_lost` is tied to 0, and the LOST state is absent.

## Test plan
- Standard frame: ID 11'h123, `rtr` = 0, 12 clean strobes → `bit_arb` sequence 0,0,1,0,0,1,0,0,0,1,1,0; `arb_complete` pulses once; `bit_counter` = 12.
- Extended frame: `identifier` 29'h12345678, `ide` = 1, `rtr` = 1 → base 11'h48D, then 1,1, then ext 18'h05678, then 1; 32 bits total; `arb_complete` after the 32nd strobe.
- Stuff handling: assert `stuff_bit_inserted` with strobes 3 and 7 of a standard frame → `bit_arb` and `bit_counter` hold; completion after 14 total strobes.
- Reserved ID: standard 11'h7F0 with `sof_complete` → `id_error` pulse; `busy` stays 0; `bit_arb` stays 1.
- Arbitration loss (macro on): extended frame, drive `rx_bit` = 0 at the SRR strobe → `arb_lost` pulse; `bit_counter` = 11; IDLE after 2 cycles; no `arb_complete`.
- Abort: assert `reset` at strobe 5, then release → all outputs at reset values. Then deassert `enable` mid-frame → clear on the next edge.

Source files
------------

// File: rtl/arbitration_field_tx_if.sv
// Bundle of the arbitration field transmitter's control and bus-side signals.
// master drives the frame request and bit timing; slave is the transmitter.
interface arbitration_field_tx_if #(
    parameter int CNT_W = 6
);
    logic             enable;
    logic             sample_point;
    logic             stuff_bit_inserted;
    logic             sof_complete;
    logic             ide;
    logic             rtr;
    logic [28:0]      identifier;
    logic             rx_bit;
    logic             bit_arb;
    logic [CNT_W-1:0] bit_counter;
    logic             arb_complete;
    logic             arb_lost;
    logic             id_error;
    logic             busy;

    modport master (
        output enable, sample_point, stuff_bit_inserted, sof_complete,
        output ide, rtr, identifier, rx_bit,
        input  bit_arb, bit_counter, arb_complete, arb_lost, id_error, busy
    );

    modport slave (
        input  enable, sample_point, stuff_bit_inserted, sof_complete,
        input  ide, rtr, identifier, rx_bit,
        output bit_arb, bit_counter, arb_complete, arb_lost, id_error, busy
    );
endinterface

// File: rtl/arbitration_field_tx.sv
// CAN arbitration field serializer (standard 11-bit / extended 29-bit IDs).
// Optional arbitration loss detection: define ARB_LOSS_DETECT_EN.
module arbitration_field_tx #(
    parameter bit EXT_SUPPORT = 1'b1,
    parameter int CNT_W       = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    arbitration_field_tx_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] LOST  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             bit_arb_q, bit_arb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             ext_q, ext_d;
    logic             rtr_q, rtr_d;
    logic [28:0]      id_q, id_d;
    logic             id_error_q, id_error_d;

    logic             ext_in;
    logic [10:0]      base_in;
    logic             reserved;
    logic             consume;
    logic [31:0]      frame;
    logic [CNT_W-1:0] last_idx;

    // Request decode and frame word assembly from the latched request.
    always_comb begin
        ext_in   = EXT_SUPPORT && bus.ide;
        base_in  = ext_in ? bus.identifier[28:18] : bus.identifier[10:0];
        reserved = (base_in[10:4] == 7'h7F);
        consume  = bus.sample_point && !bus.stuff_bit_inserted;
        if (ext_q) begin
            frame    = {id_q[28:18], 2'b11, id_q[17:0], rtr_q};
            last_idx = CNT_W'(31);
        end else begin
            frame    = {id_q[10:0], rtr_q, 20'hFFFFF};
            last_idx = CNT_W'(11);
        end
    end

    // Next-state logic; enable low overrides everything with reset values.
    always_comb begin
        state_d    = state_q;
        bit_arb_d  = bit_arb_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ext_d      = ext_q;
        rtr_d      = rtr_q;
        id_d       = id_q;
        id_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.sof_complete) begin
                    if (reserved) begin
                        id_error_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        ext_d   = ext_in;
                        rtr_d   = bus.rtr;
                        id_d    = bus.identifier;
                    end
                end
            end
            LOAD: begin
                bit_arb_d = frame[31];
                shreg_d   = {frame[30:0], 1'b1};
                cnt_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (consume) begin
`ifdef ARB_LOSS_DETECT_EN
                    if (bit_arb_q && !bus.rx_bit) begin
                        bit_arb_d = 1'b1;
                        state_d   = LOST;
                    end else
`endif
                    if (cnt_q == last_idx) begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        bit_arb_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        bit_arb_d = shreg_q[31];
                        shreg_d   = {shreg_q[30:0], 1'b1};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef ARB_LOSS_DETECT_EN
            LOST: begin
                bit_arb_d = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!bus.enable) begin
            state_d    = IDLE;
            bit_arb_d  = 1'b1;
            cnt_d      = '0;
            shreg_d    = '1;
            ext_d      = 1'b0;
            rtr_d      = 1'b0;
            id_d       = '0;
            id_error_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_arb_q  <= 1'b1;
            cnt_q      <= '0;
            shreg_q    <= '1;
            ext_q      <= 1'b0;
            rtr_q      <= 1'b0;
            id_q       <= '0;
            id_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_arb_q  <= bit_arb_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ext_q      <= ext_d;
            rtr_q      <= rtr_d;
            id_q       <= id_d;
            id_error_q <= id_error_d;
        end
    end

    assign bus.bit_arb      = bit_arb_q;
    assign bus.bit_counter  = cnt_q;
    assign bus.arb_complete = (state_q == DONE);
    assign bus.id_error     = id_error_q;
    assign bus.busy         = (state_q != IDLE);
`ifdef ARB_LOSS_DETECT_EN
    assign bus.arb_lost     = (state_q == LOST);
`else
    assign bus.arb_lost     = 1'b0;
`endif
endmodule

// File: tb/tb_arbitration_field_tx.sv
// Randomized self-checking bench for arbitration_field_tx.
// Expected bit streams come from a queue-based model of the CAN field layout.
module tb_arbitration_field_tx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic exp_q[$];

    arbitration_field_tx_if #(.CNT_W(6)) bus ();

    arbitration_field_tx #(.EXT_SUPPORT(1'b1), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Field layout: base ID, SRR, IDE, extension (extended) or ID (standard), then RTR.
    task automatic build_exp(input logic [28:0] id, input logic ide,
                             input logic rtr);
        exp_q.delete();
        if (ide) begin
            for (int i = 28; i >= 18; i--) exp_q.push_back(id[i]);
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b1);
            for (int i = 17; i >= 0; i--) exp_q.push_back(id[i]);
        end else begin
            for (int i = 10; i >= 0; i--) exp_q.push_back(id[i]);
        end
        exp_q.push_back(rtr);
    endtask

    task automatic start(input logic [28:0] id, input logic ide,
                         input logic rtr);
        build_exp(id, ide, rtr);
        bus.identifier   = id;
        bus.ide          = ide;
        bus.rtr          = rtr;
        bus.sof_complete = 1'b1;
        step();
        bus.sof_complete = 1'b0;
        chk("load_busy", bus.busy, 1);
        step();
        chk("first_bit", bus.bit_arb, exp_q[0]);
        chk("first_cnt", bus.bit_counter, 0);
    endtask

    task automatic strobe(input logic stuff, input logic rx);
        bus.sample_point       = 1'b1;
        bus.stuff_bit_inserted = stuff;
        bus.rx_bit             = rx;
        step();
        bus.sample_point       = 1'b0;
        bus.stuff_bit_inserted = 1'b0;
    endtask

    task automatic run_frame(input logic [28:0] id, input logic ide,
                             input logic rtr, input logic [63:0] mask,
                             input bit rnd, output int strobes);
        int i;
        int len;
        int k;
        logic st;
        start(id, ide, rtr);
        len = exp_q.size();
        i = 0;
        k = 0;
        while (i < len && k < 200) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.sof_complete = 1'($urandom);
                    bus.identifier   = 29'($urandom);
                    bus.ide          = 1'($urandom);
                    bus.rtr          = 1'($urandom);
                    step();
                end
            end
            bus.sof_complete = 1'b0;
            k++;
            st = (k < 64) ? mask[k] : 1'b0;
`ifdef ARB_LOSS_DETECT_EN
            strobe(st, exp_q[i]);
`else
            strobe(st, 1'($urandom));
`endif
            chk("no_lost", bus.arb_lost, 0);
            if (st) begin
                chk("stuff_bit", bus.bit_arb, exp_q[i]);
                chk("stuff_cnt", bus.bit_counter, i);
            end else begin
                i++;
                if (i < len) begin
                    chk("bit", bus.bit_arb, exp_q[i]);
                    chk("cnt", bus.bit_counter, i);
                    chk("no_done", bus.arb_complete, 0);
                end else begin
                    chk("done", bus.arb_complete, 1);
                    chk("done_cnt", bus.bit_counter, len);
                    chk("done_bit", bus.bit_arb, 1);
                end
            end
        end
        chk("frame_bound", (i == len), 1);
        step();
        chk("done_pulse", bus.arb_complete, 0);
        chk("idle_busy", bus.busy, 0);
        strobes = k;
    endtask

    initial begin
        int n;
        logic [28:0] id;
        logic ide;

        bus.enable             = 1'b1;
        bus.sample_point       = 1'b0;
        bus.stuff_bit_inserted = 1'b0;
        bus.sof_complete       = 1'b0;
        bus.ide                = 1'b0;
        bus.rtr                = 1'b0;
        bus.identifier         = '0;
        bus.rx_bit             = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("rst_bit", bus.bit_arb, 1);
        chk("rst_cnt", bus.bit_counter, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.arb_complete, 0);
        chk("rst_lost", bus.arb_lost, 0);
        chk("rst_iderr", bus.id_error, 0);

        run_frame(29'h123, 1'b0, 1'b0, 64'd0, 1'b0, n);
        chk("std_strobes", n, 12);
        run_frame(29'h12345678, 1'b1, 1'b1, 64'd0, 1'b0, n);
        chk("ext_strobes", n, 32);
        run_frame(29'h123, 1'b0, 1'b0, 64'h88, 1'b0, n);
        chk("stuff_strobes", n, 14);

        bus.identifier   = 29'h7F0;
        bus.ide          = 1'b0;
        bus.sof_complete = 1'b1;
        step();
        bus.sof_complete = 1'b0;
        chk("rsv_iderr", bus.id_error, 1);
        chk("rsv_busy", bus.busy, 0);
        chk("rsv_bit", bus.bit_arb, 1);
        step();
        chk("rsv_pulse", bus.id_error, 0);
        chk("rsv_busy2", bus.busy, 0);

        bus.identifier   = {11'h7F5, 18'h3};
        bus.ide          = 1'b1;
        bus.sof_complete = 1'b1;
        step();
        bus.sof_complete = 1'b0;
        chk("rsv_ext", bus.id_error, 1);
        chk("rsv_ext_busy", bus.busy, 0);
        step();

`ifdef ARB_LOSS_DETECT_EN
        start(29'h12345678, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) strobe(1'b0, exp_q[i]);
        strobe(1'b0, 1'b0);
        chk("lost_pulse", bus.arb_lost, 1);
        chk("lost_cnt", bus.bit_counter, 11);
        chk("lost_bit", bus.bit_arb, 1);
        chk("lost_nodone", bus.arb_complete, 0);
        step();
        chk("lost_pulse2", bus.arb_lost, 0);
        chk("lost_idle", bus.busy, 0);
        chk("lost_nodone2", bus.arb_complete, 0);
        bus.rx_bit = 1'b1;
`endif

        start(29'h2A5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) strobe(1'b0, exp_q[i]);
        bus.sample_point = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_bit", bus.bit_arb, 1);
        chk("arst_cnt", bus.bit_counter, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.arb_complete, 0);
        @(negedge clock);
        reset = 1'b0;
        bus.sample_point = 1'b0;
        step();
        chk("arst_after", bus.busy, 0);

        start(29'h15A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) strobe(1'b0, exp_q[i]);
        bus.enable = 1'b0;
        step();
        chk("en_busy", bus.busy, 0);
        chk("en_cnt", bus.bit_counter, 0);
        chk("en_bit", bus.bit_arb, 1);
        for (int i = 0; i < 10; i++) begin
            strobe(1'b0, 1'b1);
            chk("en_nodone", bus.arb_complete, 0);
        end
        bus.enable = 1'b1;
        step();

        for (int t = 0; t < 40; t++) begin
            id  = 29'($urandom);
            ide = 1'($urandom);
            if (ide && id[28:22] == 7'h7F) id[28] = 1'b0;
            if (!ide && id[10:4] == 7'h7F) id[10] = 1'b0;
            run_frame(id, ide, 1'($urandom),
                      {$urandom, $urandom} & {$urandom, $urandom}, 1'b1, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
